// File: rtl/gb_host_initiator.sv
// rtl/gb_host_initiator.sv - ghostbus host initiator: command stream to single-cycle bus strobes and responses
module gb_host_initiator #(
    parameter int AW = 24,
    parameter int DW = 32,
    parameter int RL = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_rdata,
    output logic [15:0]   txn_count
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          rdy_q;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   txn_count_q, txn_count_d;

    // rdy_q keeps cmd_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            txn_count_q <= txn_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        txn_count_d = txn_count_q;
        gb_we       = 1'b0;
        gb_re       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && rdy_q) begin
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                gb_we = we_q;
                gb_re = !we_q;
                if (we_q) begin
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d   = 4'(RL);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // counter value 1 marks the cycle the fabric presents read data
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = gb_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    txn_count_d = txn_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE) && rdy_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_we    = we_q;
    assign rsp_rdata = rdata_q;
    assign gb_addr   = addr_q;
    assign gb_wdata  = wdata_q;
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_gb_host_initiator.sv
// tb/tb_gb_host_initiator.sv - scoreboard bench for gb_host_initiator
module tb_gb_host_initiator;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata, gb_rdata;
    logic          gb_we, gb_re;
    logic [15:0]   txn_count;

    gb_host_initiator #(.AW(AW), .DW(DW), .RL(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
        .gb_rdata(gb_rdata), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    typedef struct packed {logic we; logic [DW-1:0] rdata;} rsp_t;
    typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} stb_t;
    rsp_t rsp_q[$];
    stb_t stb_q[$];
    rsp_t mr;
    stb_t ms;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Fabric model: read data appears exactly RL cycles after gb_re, 0xDEAD otherwise
    logic [DW-1:0] mem [256];
    logic [RL-1:0] re_pipe = '0;
    logic [DW-1:0] d_pipe [RL];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 32'h0000_0042;
        for (int i = 0; i < RL; i++) d_pipe[i] = '0;
    end
    always @(posedge clk) begin
        re_pipe   <= {re_pipe[RL-2:0], gb_re};
        d_pipe[0] <= mem[gb_addr[7:0]];
        for (int i = 1; i < RL; i++) d_pipe[i] <= d_pipe[i-1];
        if (gb_we) mem[gb_addr[7:0]] <= gb_wdata;
    end
    assign gb_rdata = re_pipe[RL-1] ? d_pipe[RL-1] : 32'h0000_DEAD;

    // Monitor: strobes and responses popped against expectations
    always @(negedge clk) begin
        if (gb_we || gb_re) begin
            strobes++;
            chk("strobe_exclusive", {gb_we, gb_re} == 2'b11, 0);
            chk("strobe_cmd_ready", cmd_ready, 0);
            if (stb_q.size() == 0) chk("strobe_unexpected", 1, 0);
            else begin
                ms = stb_q.pop_front();
                chk("strobe_we", gb_we, ms.we);
                chk("strobe_addr", gb_addr, ms.addr);
                if (ms.we) chk("strobe_wdata", gb_wdata, ms.wdata);
            end
        end
        if (rsp_valid && rsp_ready) begin
            chk("rsp_cmd_ready", cmd_ready, 0);
            if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                mr = rsp_q.pop_front();
                chk("rsp_we", rsp_we, mr.we);
                chk("rsp_rdata", rsp_rdata, mr.rdata);
            end
        end
    end

    // Drives a command from a falling edge and returns just after its accept edge
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp_rd);
        int n;
        stb_q.push_back({we, a, wd});
        rsp_q.push_back({we, exp_rd});
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int exp_lat);
        int lat;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 60);
        chk("rsp_latency", lat, exp_lat);
    endtask

    task automatic do_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp_rd, input int exp_lat);
        @(negedge clk);
        issue(we, a, wd, exp_rd);
        cmd_valid = 1'b0;
        wait_rsp(exp_lat);
        @(posedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || rsp_valid) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("drain_timeout", 1, 0);
    endtask

    logic          b_we   [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [AW-1:0] b_addr [8] = '{24'h10, 24'h11, 24'h12, 24'h13, 24'h10, 24'h11, 24'h12, 24'h13};
    logic [DW-1:0] b_wd   [8] = '{32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0};
    logic [DW-1:0] b_exp  [8] = '{0, 0, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44};
    time acc_t [8];
    int  s0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_gb_strobes", {gb_we, gb_re}, 0);
        chk("rst_txn", txn_count, 0);
        rst_n = 1;
        #1 chk("rel_cmd_ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1);

        do_cmd(1, 24'h40, 32'hA, 0, 2);
        @(negedge clk) chk("txn_after_write", txn_count, 1);

        do_cmd(0, 24'h0, 0, 32'h42, 2 + RL);
        @(negedge clk) chk("txn_after_read", txn_count, 2);

        s0 = strobes;
        for (int i = 0; i < 8; i++) begin
            issue(b_we[i], b_addr[i], b_wd[i], b_exp[i]);
            acc_t[i] = $time;
        end
        cmd_valid = 0;
        drain();
        @(negedge clk);
        chk("burst_strobes", strobes - s0, 8);
        chk("burst_write_gap", (acc_t[1] - acc_t[0]) / 10, 3);
        chk("txn_after_burst", txn_count, 10);

        s0 = strobes;
        rsp_ready = 0;
        issue(0, 24'h12, 0, 32'h33);
        cmd_we = 1; cmd_addr = 24'h20; cmd_wdata = 32'h55;
        wait_rsp(2 + RL);
        for (int i = 0; i < 10; i++) begin
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_rdata", rsp_rdata, 32'h33);
            chk("stall_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        chk("stall_strobes", strobes - s0, 1);
        stb_q.push_back({1'b1, 24'h20, 32'h55});
        rsp_q.push_back({1'b1, 32'h0});
        rsp_ready = 1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) chk("held_cmd_timeout", 1, 0);
            @(posedge clk);
            #1 cmd_valid = 0;
        end
        drain();
        @(negedge clk) chk("txn_after_stall", txn_count, 12);

        @(negedge clk);
        issue(0, 24'h10, 0, 32'h11);
        cmd_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        chk("arst_cmd_ready", cmd_ready, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_we_rdata", {rsp_we, rsp_rdata}, 0);
        chk("arst_gb_addr_wdata", {gb_addr, gb_wdata}, 0);
        chk("arst_strobes", {gb_we, gb_re}, 0);
        chk("arst_txn", txn_count, 0);
        rsp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
        do_cmd(1, 24'h30, 32'h77, 0, 2);
        @(negedge clk) chk("txn_after_fresh", txn_count, 1);

        force dut.txn_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.txn_count_q;
        @(negedge clk) chk("txn_preload", txn_count, 16'hFFFF);
        do_cmd(1, 24'h31, 32'h1, 0, 2);
        @(negedge clk) chk("txn_wrap", txn_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gb_host_initiator.md
# gb_host_initiator

Host-side initiator for the ghostbus register/RAM fabric: converts a valid/ready command stream into single-cycle ghostbus write or read strobes and returns one response per command. It sits at the top of the bus tree, between a host-facing transport such as a UART or Ethernet bridge and the auto-decoded ghostbus ports of the design. Address decode stays entirely in the generated fabric. The block only sequences strobes, waits out the fixed read latency, and captures read data.

## Interface
- AW, 24, ghostbus address width
- DW, 32, ghostbus data width
- RL, 1, read latency in cycles from `gb_re` high to `gb_rdata` valid; legal range 1..15
- clk  input  1  bus clock; everything is synchronous to it
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block can accept a command
- cmd_we  input  1  1 = write, 0 = read
- cmd_addr  input  AW  target address
- cmd_wdata  input  DW  write data; ignored for reads
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumer ready
- rsp_we  output  1  echoes `cmd_we` of the completed command
- rsp_rdata  output  DW  read data; 0 for writes
- gb_addr  output  AW  ghostbus address
- gb_wdata  output  DW  ghostbus write data
- gb_we  output  1  ghostbus write strobe
- gb_re  output  1  ghostbus read strobe
- gb_rdata  input  DW  ghostbus read data return
- txn_count  output  16  completed-transaction counter; wraps at 16'hFFFF -> 0

## Operation
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`: latch we/addr/wdata into holding registers, go to STROBE.
- STROBE (exactly one cycle)
  - Drive `gb_addr`/`gb_wdata` from the holding registers.
  - Assert `gb_we` if write, else `gb_re`.
  - Write: go to RESP with `rsp_rdata`=0.
  - Read: load the wait counter with RL, go to WAIT.
- WAIT
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1: capture `gb_rdata` into `rsp_rdata`, go to RESP.
  - Never more than RL cycles.
- RESP
  - `rsp_valid`=1; `rsp_we`/`rsp_rdata` held stable until `rsp_ready`.
  - On `rsp_valid`&`rsp_ready`: increment `txn_count`, go to IDLE.
- Single outstanding transaction; `cmd_ready`=0 in every state other than IDLE.
- Strobes
  - `gb_we` and `gb_re` are never high together.
  - Each is high for exactly one cycle per command.
  - Both are 0 outside STROBE.
- `gb_addr`/`gb_wdata` hold the last driven value outside STROBE. They do not toggle when no command is active.
- Reset (async assert, any state)
  - State -> IDLE.
  - All outputs 0, except `cmd_ready`=1 after the first clock edge with `rst_n` high.
  - `txn_count`=0.
  - An in-flight transaction is dropped with no response.
  - A read whose `gb_re` already fired is not replayed.

## Timing
- Command accepted on edge T.
- Write
  - `gb_we`=1 in cycle T+1.
  - `rsp_valid`=1 from T+2.
  - Best-case accept-to-accept: 3 cycles.
- Read
  - `gb_re`=1 in cycle T+1.
  - `gb_rdata` sampled at the end of cycle T+1+RL.
  - `rsp_valid`=1 from T+2+RL.
- `rsp_ready` held high in RESP: response completes that cycle, `cmd_ready`=1 the next cycle.
- `cmd_valid` arriving while not in IDLE: not accepted and not lost. The consumer keeps it asserted until `cmd_ready`.
- A response stalled by `rsp_ready`=0 blocks new commands indefinitely. No timeout.

## Test plan
- Reset, then write addr 0x000040, data 0x0000000A.
  - Required: `gb_we` pulse for 1 cycle with `gb_addr`=0x40, `gb_wdata`=0xA.
  - Required: `rsp_valid` 1 cycle later with `rsp_we`=1, `rsp_rdata`=0; `txn_count`=1.
- RL=3, read addr 0x000000 with a model returning 0x42 exactly 3 cycles after `gb_re`.
  - Required: `rsp_rdata`=0x00000042, `rsp_valid` at T+5.
  - Required: `gb_rdata` driven 0xDEAD on any other cycle is never captured.
- Back-to-back commands with `cmd_valid` held high, 4 writes followed by 4 reads.
  - Required: exactly 8 strobes, never simultaneous `gb_we`/`gb_re`.
  - Required: `cmd_ready` low from accept until response completion; `txn_count`=8.
- `rsp_ready` held low for 10 cycles on a read response.
  - Required: `rsp_valid`/`rsp_rdata` stable for all 10 cycles, `cmd_ready`=0, no further strobes.
- `rst_n` pulsed low during WAIT of a read.
  - Required: all outputs 0 immediately (asynchronous), no response, `txn_count`=0.
  - Required: a fresh write after release completes normally.
- Preload `txn_count` to 0xFFFF via 65535 writes (or force), then complete one more transaction.
  - Required: `txn_count`=0x0000.
